// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift engine.
//   Captures an operand on start_i and applies one single-bit shift per clock,
//   amount_i times, in one of four modes. The registered result appears on dout_o
//   together with a one-cycle done_o pulse.
// Ports:
//   clk_i     rising-edge clock
//   rst_i     synchronous reset, active-high; aborts any operation in flight
//   start_i   request; sampled only while busy_o=0
//   din_i     operand
//   amount_i  number of single-bit shifts (0..WIDTH-1)
//   mode_i    00 lsr, 01 asr, 10 lsl, 11 ror
//   busy_o    operation in progress (state != IDLE)
//   done_o    one-cycle pulse, dout_o holds the new result
//   dout_o    registered result, holds until the next done_o

// One-bit combinational shifter stage.
module shift_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] s_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] s_o
);
  always_comb begin
    s_o = s_i;
    unique case (mode_i)
      2'b00: s_o = {1'b0,         s_i[WIDTH-1:1]};
      2'b01: s_o = {s_i[WIDTH-1], s_i[WIDTH-1:1]};
      2'b10: s_o = {s_i[WIDTH-2:0], 1'b0};
      2'b11: s_o = {s_i[0],       s_i[WIDTH-1:1]};
      default: s_o = s_i;
    endcase
  end
endmodule

module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic [AMT_W-1:0] amount_i,
  input  logic [1:0]       mode_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] dout_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [AMT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       mode_q,  mode_d;
  logic [WIDTH-1:0] dout_q,  dout_d;
  logic [WIDTH-1:0] step_res;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .s_i    (shreg_q),
    .mode_i (mode_q),
    .s_o    (step_res)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    dout_d  = dout_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          shreg_d = din_i;
          cnt_d   = amount_i;
          mode_d  = mode_i;
          if (amount_i == '0) begin
            // Zero-length op: operand passes straight to the result.
            state_d = DONE;
            dout_d  = din_i;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        shreg_d = step_res;
        cnt_d   = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          // Last step lands directly in the result register.
          state_d = DONE;
          dout_d  = step_res;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);
  assign dout_o = dout_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer (WIDTH=8) with hand-computed results.
module tb_shift_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [7:0] din_i;
  logic [2:0] amount_i;
  logic [1:0] mode_i;
  logic       busy_o;
  logic       done_o;
  logic [7:0] dout_o;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;

  shift_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .din_i    (din_i),
    .amount_i (amount_i),
    .mode_i   (mode_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .dout_o   (dout_o)
  );

  always #5 clk_i = ~clk_i;

  // Count done pulses away from the active edge.
  always @(negedge clk_i) if (done_o === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble the operand inputs after sampling, then check
  // latency, result and the quiet cycle that follows.
  task automatic run_op(input string tag, input logic [7:0] d, input logic [2:0] a,
                        input logic [1:0] m, input logic [7:0] exp);
    int lat;
    int dc0;
    @(negedge clk_i);
    start_i = 1'b1; din_i = d; amount_i = a; mode_i = m;
    dc0 = done_cnt;
    @(posedge clk_i); #1;
    start_i = 1'b0; din_i = ~d; amount_i = ~a; mode_i = ~m;
    chk({tag, " busy"}, 32'(busy_o), 32'd1);
    lat = 1;
    while (done_o !== 1'b1 && lat < 20) begin
      @(posedge clk_i); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(a) + 32'd1);
    chk({tag, " dout"}, 32'(dout_o), 32'(exp));
    @(posedge clk_i); #1;
    chk({tag, " idle busy"}, 32'(busy_o), 32'd0);
    chk({tag, " idle done"}, 32'(done_o), 32'd0);
    chk({tag, " dout hold"}, 32'(dout_o), 32'(exp));
    chk({tag, " pulses"}, 32'(done_cnt - dc0), 32'd1);
  endtask

  initial begin
    int lat;
    int dc0;
    rst_i = 1'b1; start_i = 1'b1; din_i = 8'hAA; amount_i = 3'd2; mode_i = 2'b00;

    // 1. reset dominates start
    repeat (2) begin
      @(posedge clk_i); #1;
      chk("rst busy", 32'(busy_o), 32'd0);
      chk("rst done", 32'(done_o), 32'd0);
      chk("rst dout", 32'(dout_o), 32'd0);
    end
    @(negedge clk_i);
    rst_i = 1'b0; start_i = 1'b0;
    @(posedge clk_i); #1;
    chk("post-rst idle", 32'(busy_o), 32'd0);

    // 2-4. main function, all modes and boundary amounts
    run_op("lsr1",  8'hB4, 3'd1, 2'b00, 8'h5A);
    run_op("asr3",  8'h96, 3'd3, 2'b01, 8'hF2);
    run_op("ror3",  8'h96, 3'd3, 2'b11, 8'hD2);
    run_op("lsl3",  8'h96, 3'd3, 2'b10, 8'hB0);
    run_op("amt0",  8'h81, 3'd0, 2'b00, 8'h81);
    run_op("lsr7",  8'h81, 3'd7, 2'b00, 8'h01);
    run_op("ror7",  8'h81, 3'd7, 2'b11, 8'h03);
    run_op("lsl7",  8'h81, 3'd7, 2'b10, 8'h80);

    // 5. second start during SHIFT is ignored
    @(negedge clk_i);
    start_i = 1'b1; din_i = 8'h80; amount_i = 3'd2; mode_i = 2'b00;
    dc0 = done_cnt;
    @(negedge clk_i);
    din_i = 8'hFF; amount_i = 3'd1; mode_i = 2'b10;
    @(negedge clk_i);
    start_i = 1'b0;
    lat = 0;
    while (done_o !== 1'b1 && lat < 20) begin
      @(posedge clk_i); #1;
      lat++;
    end
    chk("busy-start dout", 32'(dout_o), 32'h20);
    repeat (4) @(posedge clk_i);
    #1;
    chk("busy-start pulses", 32'(done_cnt - dc0), 32'd1);
    chk("busy-start idle", 32'(busy_o), 32'd0);

    // 6. reset mid-operation
    @(negedge clk_i);
    start_i = 1'b1; din_i = 8'hF0; amount_i = 3'd5; mode_i = 2'b01;
    dc0 = done_cnt;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); #1;
    chk("abort pre busy", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("abort busy", 32'(busy_o), 32'd0);
    chk("abort dout", 32'(dout_o), 32'd0);
    repeat (6) @(posedge clk_i);
    #1;
    chk("abort no done", 32'(done_cnt - dc0), 32'd0);
    run_op("fresh", 8'h10, 3'd4, 2'b00, 8'h01);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
